// File: rtl/uio_arbiter.sv
// -----------------------------------------------------------------------------
// uio_arbiter
//
// Arbitrates ownership of a shared bidirectional 8-bit uio pad bus among three
// requesters. A winner is picked round-robin starting after the previous owner.
// When the winner's direction differs from the current bus direction, the bus
// spends one turnaround cycle with nothing driven before the owner gets it.
// Every output is registered.
//
// Ports
//   clk        system clock, all state on the rising edge
//   rst        asynchronous, active-high reset
//   ena        design enable; low forces the bus to be released
//   req[2:0]   per-requester level request, held until done
//   dir[2:0]   per-requester direction: 1 = drive uio, 0 = sample uio
//   wdata[23:0] requester k write byte at [8k+7:8k]
//   uio_in     pad input path
//   grant[2:0] one-hot current owner, zero when none
//   rdata      last byte captured for a sampling owner
//   rdata_vld  rdata was updated this cycle
//   uio_out    pad output path
//   uio_oe     pad output enable, 8'h00 or 8'hFF
//   busy       high in TURN or OWN
//
// Configuration
//   UIO_ARB_PREEMPT_EN  when defined, an owner that has held the bus for
//                       MAX_HOLD cycles is released if any other requester
//                       is waiting. Undefined: owner holds until req drops.
// -----------------------------------------------------------------------------
module uio_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic [2:0]  req,
  input  logic [2:0]  dir,
  input  logic [23:0] wdata,
  input  logic [7:0]  uio_in,
  output logic [2:0]  grant,
  output logic [7:0]  rdata,
  output logic        rdata_vld,
  output logic [7:0]  uio_out,
  output logic [7:0]  uio_oe,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, TURN, OWN} state_t;

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  state_t      state, state_nxt;
  logic [1:0]  owner, owner_nxt;
  logic [1:0]  last, last_nxt;
  logic        cur_dir, cur_dir_nxt;
  logic        bus_dir, bus_dir_nxt;
  logic [7:0]  hold, hold_nxt, hold_inc;
  logic [1:0]  cand, win;
  logic        found;
  logic [2:0]  grant_nxt;
  logic [7:0]  rdata_nxt, uio_out_nxt, uio_oe_nxt;
  logic        rdata_vld_nxt, busy_nxt, drive;
`ifdef UIO_ARB_PREEMPT_EN
  logic        other_req;
`endif

  function automatic logic [7:0] byte_of(input logic [23:0] w, input logic [1:0] k);
    case (k)
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[7:0];
    endcase
  endfunction

  // Round-robin search: first requester after 'last', wrapping modulo 3.
  always_comb begin
    cand  = last;
    win   = last;
    found = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_nxt   = state;
    owner_nxt   = owner;
    last_nxt    = last;
    cur_dir_nxt = cur_dir;
    bus_dir_nxt = bus_dir;
    hold_nxt    = hold;
    hold_inc    = (hold == HOLD_MAX) ? hold : hold + 8'd1;
`ifdef UIO_ARB_PREEMPT_EN
    other_req   = |(req & ~(3'b001 << owner));
`endif

    case (state)
      IDLE: begin
        if (found) begin
          owner_nxt   = win;
          cur_dir_nxt = dir[win];
          hold_nxt    = 8'd0;
          state_nxt   = (dir[win] == bus_dir) ? OWN : TURN;
        end
      end
      TURN: begin
        state_nxt   = OWN;
        bus_dir_nxt = cur_dir;
        hold_nxt    = 8'd0;
      end
      OWN: begin
        hold_nxt = hold_inc;
        if (!req[owner]) begin
          state_nxt = IDLE;
          last_nxt  = owner;
`ifdef UIO_ARB_PREEMPT_EN
        // hold_inc counts the current cycle, so the owner gets exactly
        // MAX_HOLD cycles before a forced release.
        end else if (hold_inc == HOLD_MAX && other_req) begin
          state_nxt = IDLE;
          last_nxt  = owner;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Disable overrides everything: release and park the bus as a sampler.
    if (!ena) begin
      state_nxt   = IDLE;
      last_nxt    = last;
      bus_dir_nxt = 1'b0;
      hold_nxt    = 8'd0;
    end

    // Registered outputs are derived from the state being entered.
    drive         = (state_nxt == OWN) && cur_dir_nxt;
    grant_nxt     = (state_nxt == OWN) ? (3'b001 << owner_nxt) : 3'b000;
    uio_oe_nxt    = drive ? 8'hFF : 8'h00;
    uio_out_nxt   = drive ? byte_of(wdata, owner_nxt) : 8'h00;
    rdata_vld_nxt = (state_nxt == OWN) && !cur_dir_nxt;
    rdata_nxt     = rdata_vld_nxt ? uio_in : rdata;
    busy_nxt      = (state_nxt != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= 2'd0;
      last      <= 2'd2;
      cur_dir   <= 1'b0;
      bus_dir   <= 1'b0;
      hold      <= 8'd0;
      grant     <= 3'b000;
      rdata     <= 8'h00;
      rdata_vld <= 1'b0;
      uio_out   <= 8'h00;
      uio_oe    <= 8'h00;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      last      <= last_nxt;
      cur_dir   <= cur_dir_nxt;
      bus_dir   <= bus_dir_nxt;
      hold      <= hold_nxt;
      grant     <= grant_nxt;
      rdata     <= rdata_nxt;
      rdata_vld <= rdata_vld_nxt;
      uio_out   <= uio_out_nxt;
      uio_oe    <= uio_oe_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule
